// File: rtl/wb_port_arbiter_pkg.sv
// Shared defaults and entry layout for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned DefDw = 32;
  localparam int unsigned DefAw = 5;

  // r0 is hard-wired to zero and never written.
  localparam logic [DefAw-1:0] RegZero = '0;

  typedef struct packed {
    logic             valid;
    logic [DefAw-1:0] rw;
    logic [DefDw-1:0] wdata;
  } fifo_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer for long-latency results with per-entry squash by destination index.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned AW    = DefAw
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [AW-1:0]                 push_rw_i,
  input  logic [DW-1:0]                 push_wdata_i,
  input  logic                          pop_i,
  input  logic                          squash_en_i,
  input  logic [AW-1:0]                 squash_rw_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          head_valid_o,
  output logic [AW-1:0]                 head_rw_o,
  output logic [DW-1:0]                 head_wdata_o,
  output logic [$clog2(Depth)-1:0]      head_idx_o,
  output logic [Depth-1:0]              ent_valid_o,
  output logic [Depth-1:0][AW-1:0]      ent_rw_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0]         valid_q, valid_d;
  logic [Depth-1:0][AW-1:0] rw_q, rw_d;
  logic [Depth-1:0][DW-1:0] data_q, data_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     push_ok, pop_ok;

  assign full_o       = (cnt_q == CntW'(Depth));
  assign empty_o      = (cnt_q == '0);
  assign push_ok      = push_i && !full_o;
  assign pop_ok       = pop_i && !empty_o;
  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_rw_o    = rw_q[rd_ptr_q];
  assign head_wdata_o = data_q[rd_ptr_q];
  assign head_idx_o   = rd_ptr_q;
  assign ent_valid_o  = valid_q;
  assign ent_rw_o     = rw_q;

  always_comb begin
    valid_d  = valid_q;
    rw_d     = rw_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // A squashed slot keeps its place in the queue; only its valid bit drops.
    for (int unsigned i = 0; i < Depth; i++) begin
      if (squash_en_i && valid_q[i] && (rw_q[i] == squash_rw_i)) valid_d[i] = 1'b0;
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      rw_d[wr_ptr_q]    = push_rw_i;
      data_d[wr_ptr_q]  = push_wdata_i;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload is only observed through a set valid bit, so it needs no reset.
  always_ff @(posedge clk_i) begin
    rw_q   <= rw_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results buffered.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DW         = DefDw,
  parameter int unsigned AW         = DefAw,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_wr_en,
  input  logic [AW-1:0]      pipe_rw,
  input  logic [DW-1:0]      pipe_wdata,
  input  logic               lu_valid,
  input  logic [AW-1:0]      lu_rw,
  input  logic [DW-1:0]      lu_wdata,
  output logic               lu_ready,
  output logic               reg_fileWr,
  output logic [AW-1:0]      Rw,
  output logic [DW-1:0]      busW,
  output logic [2**AW-1:0]   pend_mask,
  output logic               stall_req
);

  localparam int unsigned NumRegs = 2 ** AW;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned StW     = $clog2(STARVE_MAX + 1);

  logic                          pipe_req, lu_xfer, push, pop;
  logic                          fifo_full, fifo_empty, head_valid;
  logic [AW-1:0]                 head_rw;
  logic [DW-1:0]                 head_wdata;
  logic [PtrW-1:0]               head_idx;
  logic [FIFO_DEPTH-1:0]         ent_valid;
  logic [FIFO_DEPTH-1:0][AW-1:0] ent_rw;

  logic               wr_q, wr_d;
  logic [AW-1:0]      rw_q, rw_d;
  logic [DW-1:0]      busw_q, busw_d;
  logic [NumRegs-1:0] pend_q, pend_d;
  logic               stall_q, stall_d;
  logic [StW-1:0]     starve_q, starve_d;

  // A pipeline write to r0 is not a request, which frees the port for the FIFO.
  assign pipe_req = pipe_wr_en && (pipe_rw != AW'(RegZero));
  assign lu_ready = !fifo_full && !rst;
  assign lu_xfer  = lu_valid && lu_ready;
  // Discarded transfers (r0, or overtaken by a same-cycle pipeline write) complete but store nothing.
  assign push     = lu_xfer && (lu_rw != AW'(RegZero)) && !(pipe_req && (lu_rw == pipe_rw));
  assign pop      = !pipe_req && !fifo_empty;

  wb_result_fifo #(
    .Depth (FIFO_DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_rw_i    (lu_rw),
    .push_wdata_i (lu_wdata),
    .pop_i        (pop),
    .squash_en_i  (pipe_req),
    .squash_rw_i  (pipe_rw),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_valid_o (head_valid),
    .head_rw_o    (head_rw),
    .head_wdata_o (head_wdata),
    .head_idx_o   (head_idx),
    .ent_valid_o  (ent_valid),
    .ent_rw_o     (ent_rw)
  );

  always_comb begin
    wr_d   = 1'b0;
    rw_d   = rw_q;
    busw_d = busw_q;
    if (pipe_req) begin
      wr_d   = 1'b1;
      rw_d   = pipe_rw;
      busw_d = pipe_wdata;
    end else if (pop && head_valid) begin
      wr_d   = 1'b1;
      rw_d   = head_rw;
      busw_d = head_wdata;
    end
  end

  // Pending mask mirrors the FIFO contents as they will stand after this cycle.
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && !(pop && (head_idx == PtrW'(i))) &&
          !(pipe_req && (ent_rw[i] == pipe_rw))) begin
        pend_d[ent_rw[i]] = 1'b1;
      end
    end
    if (push) pend_d[lu_rw] = 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != StW'(STARVE_MAX)) begin
      starve_d = starve_q + StW'(1);
    end
    stall_d = pop ? 1'b0 : (stall_q || (starve_q == StW'(STARVE_MAX)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
      pend_q   <= '0;
      stall_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
      pend_q   <= pend_d;
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign reg_fileWr = wr_q;
  assign Rw         = rw_q;
  assign busW       = busw_q;
  assign pend_mask  = pend_q;
  assign stall_req  = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter with a scoreboard queue of expected port state.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en, lu_valid;
  logic [4:0]  pipe_rw, lu_rw;
  logic [31:0] pipe_wdata, lu_wdata;
  logic        lu_ready, reg_fileWr, stall_req;
  logic [4:0]  Rw;
  logic [31:0] busW, pend_mask;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DW         (32),
    .AW         (5),
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_wr_en (pipe_wr_en),
    .pipe_rw    (pipe_rw),
    .pipe_wdata (pipe_wdata),
    .lu_valid   (lu_valid),
    .lu_rw      (lu_rw),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .reg_fileWr (reg_fileWr),
    .Rw         (Rw),
    .busW       (busW),
    .pend_mask  (pend_mask),
    .stall_req  (stall_req)
  );

  typedef struct {
    logic        rst, pwe;
    logic [4:0]  prw;
    logic [31:0] pwd;
    logic        luv;
    logic [4:0]  lurw;
    logic [31:0] luwd;
    logic        e_ready, e_wr;
    logic [4:0]  e_rw;
    logic [31:0] e_bus, e_pend;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] bus, pend;
    logic        stall;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(input logic r, input logic pwe, input int prw,
                              input logic [31:0] pwd, input logic luv, input int lurw,
                              input logic [31:0] luwd, input logic er, input logic ew,
                              input int erw, input logic [31:0] eb, input logic [31:0] ep,
                              input logic es);
    vec_t v;
    v.rst = r; v.pwe = pwe; v.prw = 5'(prw); v.pwd = pwd;
    v.luv = luv; v.lurw = 5'(lurw); v.luwd = luwd;
    v.e_ready = er; v.e_wr = ew; v.e_rw = 5'(erw); v.e_bus = eb; v.e_pend = ep; v.e_stall = es;
    return v;
  endfunction

  function automatic logic [31:0] bm(input int n);
    return 32'h1 << n;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; pipe_wr_en = v.pwe; pipe_rw = v.prw; pipe_wdata = v.pwd;
    lu_valid = v.luv; lu_rw = v.lurw; lu_wdata = v.luwd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    logic got;
    rst = 1'b1; pipe_wr_en = 1'b0; pipe_rw = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_rw = '0; lu_wdata = '0;

    // rst pwe prw pwd luv lurw luwd | ready wr rw bus pend stall
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, 0, 1, 3, 32'h55, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // idle-pipe drain
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 32'h12345678, 1, 0, 0, 0, bm(5), 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 32'h12345678, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 32'h12345678, 0, 0));
    // priority and starvation
    vecs.push_back(mk(0, 1, 1, 32'h101, 1, 9, 32'h99, 1, 1, 1, 32'h101, bm(9), 0));
    vecs.push_back(mk(0, 1, 2, 32'h102, 0, 0, 0, 1, 1, 2, 32'h102, bm(9), 0));
    vecs.push_back(mk(0, 1, 3, 32'h103, 0, 0, 0, 1, 1, 3, 32'h103, bm(9), 0));
    vecs.push_back(mk(0, 1, 4, 32'h104, 0, 0, 0, 1, 1, 4, 32'h104, bm(9), 0));
    vecs.push_back(mk(0, 1, 5, 32'h105, 0, 0, 0, 1, 1, 5, 32'h105, bm(9), 0));
    vecs.push_back(mk(0, 1, 6, 32'h106, 0, 0, 0, 1, 1, 6, 32'h106, bm(9), 1));
    vecs.push_back(mk(0, 1, 7, 32'h107, 0, 0, 0, 1, 1, 7, 32'h107, bm(9), 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 32'h99, 0, 0));
    // squash of a buffered entry by a younger pipeline write
    vecs.push_back(mk(0, 1, 1, 32'h11, 1, 7, 32'hAAAA, 1, 1, 1, 32'h11, bm(7), 0));
    vecs.push_back(mk(0, 1, 7, 32'hBBBB, 0, 0, 0, 1, 1, 7, 32'hBBBB, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 32'hBBBB, 0, 0));
    // full and back-pressure, third transfer held
    vecs.push_back(mk(0, 1, 1, 32'h21, 1, 10, 32'hA0, 1, 1, 1, 32'h21, bm(10), 0));
    vecs.push_back(mk(0, 1, 2, 32'h22, 1, 11, 32'hB0, 1, 1, 2, 32'h22, bm(10) | bm(11), 0));
    vecs.push_back(mk(0, 1, 3, 32'h23, 1, 12, 32'hC0, 0, 1, 3, 32'h23, bm(10) | bm(11), 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 12, 32'hC0, 0, 1, 10, 32'hA0, bm(11), 0));
    vecs.push_back(mk(0, 1, 4, 32'h24, 1, 12, 32'hC0, 1, 1, 4, 32'h24, bm(11) | bm(12), 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hB0, bm(12), 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 32'hC0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 12, 32'hC0, 0, 0));
    // r0 handling
    vecs.push_back(mk(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0, 12, 32'hC0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 12, 32'hC0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h31, 1, 13, 32'hD0, 1, 1, 1, 32'h31, bm(13), 0));
    vecs.push_back(mk(0, 1, 0, 32'hEEEE, 0, 0, 0, 1, 1, 13, 32'hD0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 13, 32'hD0, 0, 0));
    // reset mid-operation drops the buffered entry
    vecs.push_back(mk(0, 1, 1, 32'h41, 1, 14, 32'hE0, 1, 1, 1, 32'h41, bm(14), 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("lu_ready", i, 32'(lu_ready), 32'(vecs[i].e_ready));
      sb.push_back('{vecs[i].e_wr, vecs[i].e_rw, vecs[i].e_bus, vecs[i].e_pend, vecs[i].e_stall});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL scoreboard[%0d]: got empty want entry", i);
      end else begin
        e = sb.pop_front();
        chk("reg_fileWr", i, 32'(reg_fileWr), 32'(e.wr));
        chk("Rw", i, 32'(Rw), 32'(e.rw));
        chk("busW", i, busW, e.bus);
        chk("pend_mask", i, pend_mask, e.pend);
        chk("stall_req", i, 32'(stall_req), 32'(e.stall));
      end
    end

    // Starvation latency measured with a bounded wait on stall_req.
    @(negedge clk);
    pipe_wr_en = 1'b1; pipe_rw = 5'd1; pipe_wdata = 32'h51;
    lu_valid = 1'b1; lu_rw = 5'd20; lu_wdata = 32'hF0;
    @(posedge clk);
    #1;
    chk("seq_pend20", 0, pend_mask, bm(20));
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      lu_valid = 1'b0; pipe_wr_en = 1'b1; pipe_rw = 5'(n + 2); pipe_wdata = 32'h60 + 32'(n);
      @(posedge clk);
      #1;
      n++;
      if (stall_req) got = 1'b1;
    end
    chk("seq_stall_cycles", 0, 32'(n), 32'd5);
    @(negedge clk);
    pipe_wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("seq_drain_wr", 0, 32'(reg_fileWr), 32'd1);
    chk("seq_drain_rw", 0, 32'(Rw), 32'd20);
    chk("seq_drain_bus", 0, busW, 32'hF0);
    chk("seq_drain_stall", 0, 32'(stall_req), 32'd0);
    chk("seq_drain_pend", 0, pend_mask, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
